mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage sitting directly downstream of the execute stage (ALU). It consumes the execute result, valid strobe and flags, performs at most one 64-bit-bus load or store per instruction through a valid/ready request port, and produces a single-cycle writeback record for the register file. While a memory transaction is outstanding it asserts `mem_blocked`, which freezes the execute stage's output registers.

## Interface
- `TIMEOUT_CYCLES`, 255: response watchdog limit in cycles; only used with `MEM_STAGE_TIMEOUT_EN`.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset, sampled on `clk`.
- `exe_mem`  in  1  execute output valid.
- `ex_result`  in  128  `[63:0]` = ALU value / effective address; `[127:64]` = store data.
- `ex_rflags`  in  64  flags from execute.
- `ex_mem_op`  in  2  NONE=0, LOAD=1, STORE=2; 3 is treated as NONE.
- `ex_size`  in  2  access size: 0=1B, 1=2B, 2=4B, 3=8B.
- `ex_sext`  in  1  sign-extend load data.
- `ex_dest`  in  4  destination GPR index.
- `ex_wb_en`  in  1  instruction writes `ex_dest`.
- `mem_blocked`  out  1  stall to execute.
- `mreq_valid`  out  1  memory request valid.
- `mreq_ready`  in  1  memory request accepted.
- `mreq_addr`  out  64  8-byte-aligned address, `{addr[63:3],3'b0}`.
- `mreq_we`  out  1  1 = store.
- `mreq_wdata`  out  64  store data, lane-shifted.
- `mreq_be`  out  8  byte enables.
- `mresp_valid`  in  1  response / store acknowledge.
- `mresp_rdata`  in  64  load data, full aligned word.
- `wb_valid`  out  1  one-cycle retire pulse.
- `wb_we`  out  1  register write enable.
- `wb_dest`  out  4  register index.
- `wb_data`  out  64  writeback value.
- `wb_rflags`  out  64  flags, passed through.
- `wb_err`  out  1  misaligned access or timeout.

## Operation
- FSM states: IDLE, REQ, WAIT.
- `mem_blocked` = (state != IDLE), decoded directly from the state register.
- **IDLE, `exe_mem`=1:**
  - Capture all `ex_*` fields.
  - NONE: retire next cycle with `wb_data=ex_result[63:0]` and `wb_we=ex_wb_en`; stay in IDLE.
  - LOAD/STORE, aligned: go to REQ.
  - LOAD/STORE, misaligned (`addr[2:0] + size_bytes > 8`): no request is issued; retire next cycle with `wb_err=1` and `wb_we=0`; stay in IDLE.
- **REQ:**
  - `mreq_valid=1`, with address, write enable, data and byte enables held stable.
  - On `mreq_ready` go to WAIT; `mreq_valid` drops the next cycle.
- **WAIT:**
  - On `mresp_valid`, retire and go to IDLE.
  - Load: `wb_data` = bytes `rdata[8*a +: 8*n]`, zero- or sign-extended to 64 bits, where a = `addr[2:0]` and n = size bytes; `wb_we=ex_wb_en`.
  - Store: `wb_data=0`, `wb_we=ex_wb_en`.
- **Store encoding:** `mreq_be = ((1<<n)-1) << a`; `mreq_wdata = store_data << 8*a`.
- `exe_mem` is ignored outside IDLE. Execute holds its next result while blocked, and that result is captured on the first IDLE cycle, so it is consumed exactly once.
- `mresp_valid` arriving outside WAIT is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - Outputs: `mem_blocked`, `mreq_valid`, `mreq_we`, `wb_valid`, `wb_we`, `wb_err` = 0.
  - Buses: `mreq_addr`, `mreq_wdata`, `mreq_be`, `wb_dest`, `wb_data`, `wb_rflags` = 0.
- Reset mid-transaction: the request is abandoned, no writeback occurs, and the FSM returns to IDLE on the same edge.
- Latencies:
  - Non-memory op: `wb_valid` 1 cycle after capture.
  - Memory op: `mem_blocked` from capture+1; `wb_valid` 1 cycle after `mresp_valid` is sampled. In that same cycle `mem_blocked=0`.
- Best case for a memory op: capture at cycle 0, `mreq_ready` at cycle 1, `mresp_valid` at cycle 2, `wb_valid` at cycle 3.
- Back-to-back non-memory ops sustain one retire per cycle.
- `wb_valid` is a single-cycle pulse; all `wb_*` outputs are registered.

## Configuration
- `MEM_STAGE_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching `TIMEOUT_CYCLES` without `mresp_valid`: retire with `wb_err=1` and `wb_we=0`, then go to IDLE.
  - A response on the same cycle as the limit wins; no error is raised.
- Undefined: no counter; WAIT persists indefinitely.

## Structure
- Shared package `mem_pkg`:
  - `mem_op_t` and `mem_size_t` enums.
  - `mem_state_t` (IDLE/REQ/WAIT).
  - Function `size_bytes(mem_size_t)`.
- Sub-module `mem_align` (combinational): address offset + size + sign-extend → byte enables, shifted write data, extracted load data, misalign flag.
- The FSM and registers live in `mem_stage`.

## Test plan
- **Non-memory op:** NONE op, `ex_result[63:0]=0x1234`, `ex_dest=3`, `wb_en=1` → next cycle `wb_valid=1`, `wb_dest=3`, `wb_data=0x1234`, `mem_blocked` stays 0.
- **Sign-extended load:** LOAD, size 1B, sext, addr `0x1005`, `mresp_rdata=0x0000_8000_0000_0000` → `mreq_addr=0x1000`, `wb_data=0xFFFF_FFFF_FFFF_FF80`; `mem_blocked` high from capture+1 until the retire cycle.
- **Store with stall:** STORE 4B to addr `0x2004`, data `0xDEADBEEF`, `mreq_ready` delayed 3 cycles → `mreq_be=0xF0`, `mreq_wdata=0xDEADBEEF_0000_0000`; `mreq_valid` and fields stable throughout the stall.
- **Misaligned access:** 8B load at `0x3003` → no `mreq_valid`; next cycle `wb_valid=1`, `wb_err=1`, `wb_we=0`.
- **Reset in WAIT:** assert `reset_n=0` while in WAIT → all outputs 0 next cycle; a later `mresp_valid` produces no `wb_valid`.
- **Timeout** (`MEM_STAGE_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`): no response → `wb_err` pulse 4 cycles after entering WAIT; the held execute result is captured on the following IDLE cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg : shared types and helpers for the memory-access stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    SZ_1B = 2'd0,
    SZ_2B = 2'd1,
    SZ_4B = 2'd2,
    SZ_8B = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_t;

  // Instruction context held from capture until retire.
  typedef struct packed {
    mem_op_t     op;
    mem_size_t   size;
    logic        sext;
    logic [2:0]  off;
    logic [3:0]  dest;
    logic        wb_en;
    logic [63:0] rflags;
  } mem_ctx_t;

  function automatic logic [3:0] size_bytes(input mem_size_t sz);
    case (sz)
      SZ_1B:   size_bytes = 4'd1;
      SZ_2B:   size_bytes = 4'd2;
      SZ_4B:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

  // Encoding 3 is reserved and behaves as a non-memory op.
  function automatic mem_op_t op_decode(input logic [1:0] raw);
    case (raw)
      2'd1:    op_decode = OP_LOAD;
      2'd2:    op_decode = OP_STORE;
      default: op_decode = OP_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// ----------------------------------------------------------------------------
// mem_align : byte-lane steering for 64-bit bus accesses (combinational)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  off_i,
  input  mem_size_t   size_i,
  input  logic        sext_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [63:0] ldata_o,
  output logic        misalign_o
);

  logic [7:0]  w_mask;
  logic [63:0] w_rshift;

  always_comb begin
    case (size_i)
      SZ_1B:   w_mask = 8'h01;
      SZ_2B:   w_mask = 8'h03;
      SZ_4B:   w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
    be_o       = w_mask << off_i;
    wdata_o    = wdata_i << {off_i, 3'b000};
    misalign_o = ({1'b0, off_i} + size_bytes(size_i)) > 4'd8;
    w_rshift   = rdata_i >> {off_i, 3'b000};
    case (size_i)
      SZ_1B:   ldata_o = {{56{sext_i & w_rshift[7]}},  w_rshift[7:0]};
      SZ_2B:   ldata_o = {{48{sext_i & w_rshift[15]}}, w_rshift[15:0]};
      SZ_4B:   ldata_o = {{32{sext_i & w_rshift[31]}}, w_rshift[31:0]};
      default: ldata_o = w_rshift;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage : memory-access pipeline stage with valid/ready request port.
// Optional response watchdog enabled by MEM_STAGE_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          exe_mem,
  input  logic [127:0]  ex_result,
  input  logic [63:0]   ex_rflags,
  input  logic [1:0]    ex_mem_op,
  input  logic [1:0]    ex_size,
  input  logic          ex_sext,
  input  logic [3:0]    ex_dest,
  input  logic          ex_wb_en,
  output logic          mem_blocked,
  output logic          mreq_valid,
  input  logic          mreq_ready,
  output logic [63:0]   mreq_addr,
  output logic          mreq_we,
  output logic [63:0]   mreq_wdata,
  output logic [7:0]    mreq_be,
  input  logic          mresp_valid,
  input  logic [63:0]   mresp_rdata,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [3:0]    wb_dest,
  output logic [63:0]   wb_data,
  output logic [63:0]   wb_rflags,
  output logic          wb_err
);

  mem_state_t  state_q, state_d;
  mem_ctx_t    ctx_q, ctx_d;
  logic [63:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  be_q, be_d;
  logic [63:0] wdata_q, wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic        wb_err_q, wb_err_d;
  logic [3:0]  wb_dest_q, wb_dest_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic [63:0] wb_rflags_q, wb_rflags_d;

  mem_op_t     w_ex_op;
  logic        w_idle;
  logic [2:0]  w_off;
  mem_size_t   w_size;
  logic        w_sext;
  logic [7:0]  w_be;
  logic [63:0] w_wdata;
  logic [63:0] w_ldata;
  logic        w_misalign;
  logic        w_timeout;

  assign w_ex_op = op_decode(ex_mem_op);
  assign w_idle  = (state_q == ST_IDLE);

  // One aligner serves both phases: live execute fields while idle, captured ones afterwards.
  assign w_off  = w_idle ? ex_result[2:0]       : ctx_q.off;
  assign w_size = w_idle ? mem_size_t'(ex_size) : ctx_q.size;
  assign w_sext = w_idle ? ex_sext              : ctx_q.sext;

  mem_align u_align (
    .off_i      (w_off),
    .size_i     (w_size),
    .sext_i     (w_sext),
    .wdata_i    (ex_result[127:64]),
    .rdata_i    (mresp_rdata),
    .be_o       (w_be),
    .wdata_o    (w_wdata),
    .ldata_o    (w_ldata),
    .misalign_o (w_misalign)
  );

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || state_q != ST_WAIT) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign w_timeout = (state_q == ST_WAIT) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (exe_mem && w_ex_op != OP_NONE && !w_misalign) state_d = ST_REQ;
      ST_REQ:  if (mreq_ready) state_d = ST_WAIT;
      ST_WAIT: if (mresp_valid || w_timeout) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_blocked = (state_q != ST_IDLE);
    mreq_valid  = (state_q == ST_REQ);
  end

  always_comb begin
    ctx_d       = ctx_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_err_d    = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    wb_rflags_d = wb_rflags_q;

    if (w_idle && exe_mem) begin
      ctx_d.op     = w_ex_op;
      ctx_d.size   = mem_size_t'(ex_size);
      ctx_d.sext   = ex_sext;
      ctx_d.off    = ex_result[2:0];
      ctx_d.dest   = ex_dest;
      ctx_d.wb_en  = ex_wb_en;
      ctx_d.rflags = ex_rflags;
      if (w_ex_op == OP_NONE || w_misalign) begin
        wb_valid_d  = 1'b1;
        wb_dest_d   = ex_dest;
        wb_rflags_d = ex_rflags;
        wb_err_d    = (w_ex_op != OP_NONE);
        wb_we_d     = (w_ex_op == OP_NONE) && ex_wb_en;
        wb_data_d   = (w_ex_op == OP_NONE) ? ex_result[63:0] : 64'd0;
      end else begin
        addr_d  = {ex_result[63:3], 3'b000};
        we_d    = (w_ex_op == OP_STORE);
        be_d    = w_be;
        wdata_d = (w_ex_op == OP_STORE) ? w_wdata : 64'd0;
      end
    end else if (state_q == ST_WAIT && (mresp_valid || w_timeout)) begin
      // A response arriving on the limit cycle takes priority over the timeout.
      wb_valid_d  = 1'b1;
      wb_dest_d   = ctx_q.dest;
      wb_rflags_d = ctx_q.rflags;
      wb_err_d    = !mresp_valid;
      wb_we_d     = mresp_valid && ctx_q.wb_en;
      wb_data_d   = (mresp_valid && ctx_q.op == OP_LOAD) ? w_ldata : 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctx_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
      wb_rflags_q <= '0;
    end else begin
      ctx_q       <= ctx_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_err_q    <= wb_err_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      wb_rflags_q <= wb_rflags_d;
    end
  end

  assign mreq_addr  = addr_q;
  assign mreq_we    = we_q;
  assign mreq_be    = be_q;
  assign mreq_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_err     = wb_err_q;
  assign wb_dest    = wb_dest_q;
  assign wb_data    = wb_data_q;
  assign wb_rflags  = wb_rflags_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage : directed vector bench for mem_stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         exe_mem;
  logic [127:0] ex_result;
  logic [63:0]  ex_rflags;
  logic [1:0]   ex_mem_op;
  logic [1:0]   ex_size;
  logic         ex_sext;
  logic [3:0]   ex_dest;
  logic         ex_wb_en;
  logic         mem_blocked;
  logic         mreq_valid;
  logic         mreq_ready;
  logic [63:0]  mreq_addr;
  logic         mreq_we;
  logic [63:0]  mreq_wdata;
  logic [7:0]   mreq_be;
  logic         mresp_valid;
  logic [63:0]  mresp_rdata;
  logic         wb_valid;
  logic         wb_we;
  logic [3:0]   wb_dest;
  logic [63:0]  wb_data;
  logic [63:0]  wb_rflags;
  logic         wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .exe_mem(exe_mem), .ex_result(ex_result),
    .ex_rflags(ex_rflags), .ex_mem_op(ex_mem_op), .ex_size(ex_size), .ex_sext(ex_sext),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .mem_blocked(mem_blocked),
    .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .mreq_addr(mreq_addr),
    .mreq_we(mreq_we), .mreq_wdata(mreq_wdata), .mreq_be(mreq_be),
    .mresp_valid(mresp_valid), .mresp_rdata(mresp_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data), .wb_rflags(wb_rflags),
    .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        sext;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [3:0]  dest;
    logic        wb_en;
    logic [63:0] rflags;
    logic [63:0] rdata;
    int          delay;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
    logic        exp_wb_we;
    logic        chk_data;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [1:0] size, input logic sext,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [3:0] dest, input logic wb_en, input logic [63:0] rflags);
    exe_mem   = 1'b1;
    ex_mem_op = op;
    ex_size   = size;
    ex_sext   = sext;
    ex_result = {sdata, addr};
    ex_dest   = dest;
    ex_wb_en  = wb_en;
    ex_rflags = rflags;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    drive_op(v.op, v.size, v.sext, v.addr, v.sdata, v.dest, v.wb_en, v.rflags);
    tick();
    exe_mem = 1'b0;
    if (!v.exp_req) begin
      chk({p, " mreq_valid"}, 64'(mreq_valid), 64'd0);
      chk({p, " blocked"},    64'(mem_blocked), 64'd0);
    end else begin
      chk({p, " blocked"},    64'(mem_blocked), 64'd1);
      chk({p, " mreq_valid"}, 64'(mreq_valid), 64'd1);
      chk({p, " mreq_addr"},  mreq_addr, v.exp_addr);
      chk({p, " mreq_we"},    64'(mreq_we), 64'(v.op == 2'd2));
      if (v.op == 2'd2) begin
        chk({p, " mreq_be"},    64'(mreq_be), 64'(v.exp_be));
        chk({p, " mreq_wdata"}, mreq_wdata, v.exp_wdata);
      end
      for (int d = 0; d < v.delay; d++) begin
        tick();
        chk({p, " stall valid"}, 64'(mreq_valid), 64'd1);
        chk({p, " stall addr"},  mreq_addr, v.exp_addr);
        if (v.op == 2'd2) begin
          chk({p, " stall be"},    64'(mreq_be), 64'(v.exp_be));
          chk({p, " stall wdata"}, mreq_wdata, v.exp_wdata);
        end
      end
      mreq_ready = 1'b1;
      tick();
      mreq_ready = 1'b0;
      chk({p, " wait valid"},   64'(mreq_valid), 64'd0);
      chk({p, " wait blocked"}, 64'(mem_blocked), 64'd1);
      chk({p, " wait wb"},      64'(wb_valid), 64'd0);
      mresp_valid = 1'b1;
      mresp_rdata = v.rdata;
      tick();
      mresp_valid = 1'b0;
      chk({p, " retire blocked"}, 64'(mem_blocked), 64'd0);
    end
    chk({p, " wb_valid"},  64'(wb_valid), 64'd1);
    chk({p, " wb_err"},    64'(wb_err), 64'(v.exp_err));
    chk({p, " wb_we"},     64'(wb_we), 64'(v.exp_wb_we));
    chk({p, " wb_dest"},   64'(wb_dest), 64'(v.dest));
    chk({p, " wb_rflags"}, wb_rflags, v.rflags);
    if (v.chk_data) chk({p, " wb_data"}, wb_data, v.exp_data);
    tick();
    chk({p, " pulse"}, 64'(wb_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    //        op    sz    sx addr                   sdata                 dst   en rflags  rdata                  dly req  exp_addr               be     wdata                  wbwe chk exp_data               err
    vecs[0]  = '{2'd0, 2'd0, 0, 64'h1234,             64'h0,                4'd3, 1, 64'hA1, 64'h0,                 0, 0, 64'h0,                 8'h00, 64'h0,                 1, 1, 64'h1234,              0};
    vecs[1]  = '{2'd1, 2'd0, 1, 64'h1005,             64'h0,                4'd5, 1, 64'hB2, 64'h0000_8000_0000_0000, 0, 1, 64'h1000,            8'h00, 64'h0,                 1, 1, 64'hFFFF_FFFF_FFFF_FF80, 0};
    vecs[2]  = '{2'd2, 2'd2, 0, 64'h2004,             64'hDEADBEEF,         4'd7, 0, 64'hC3, 64'h0,                 3, 1, 64'h2000,              8'hF0, 64'hDEADBEEF_0000_0000, 0, 1, 64'h0,                 0};
    vecs[3]  = '{2'd1, 2'd3, 0, 64'h3003,             64'h0,                4'd2, 1, 64'hD4, 64'h0,                 0, 0, 64'h0,                 8'h00, 64'h0,                 0, 0, 64'h0,                 1};
    vecs[4]  = '{2'd1, 2'd1, 0, 64'h4006,             64'h0,                4'd4, 1, 64'hE5, 64'hBEEF_0000_0000_0000, 1, 1, 64'h4000,            8'h00, 64'h0,                 1, 1, 64'h0000_0000_0000_BEEF, 0};
    vecs[5]  = '{2'd1, 2'd2, 1, 64'h10,               64'h0,                4'd6, 1, 64'hF6, 64'h1234_5678_8765_4321, 0, 1, 64'h10,              8'h00, 64'h0,                 1, 1, 64'hFFFF_FFFF_8765_4321, 0};
    vecs[6]  = '{2'd2, 2'd0, 0, 64'h7,                64'hAB,               4'd1, 1, 64'h17, 64'h0,                 2, 1, 64'h0,                 8'h80, 64'hAB00_0000_0000_0000, 1, 1, 64'h0,                 0};
    vecs[7]  = '{2'd2, 2'd1, 0, 64'h107,              64'h5566,             4'd8, 1, 64'h28, 64'h0,                 0, 0, 64'h0,                 8'h00, 64'h0,                 0, 0, 64'h0,                 1};
    vecs[8]  = '{2'd1, 2'd3, 1, 64'h8,                64'h0,                4'd15,1, 64'h39, 64'h0123_4567_89AB_CDEF, 0, 1, 64'h8,               8'h00, 64'h0,                 1, 1, 64'h0123_4567_89AB_CDEF, 0};
    vecs[9]  = '{2'd3, 2'd3, 0, 64'h55,               64'h0,                4'd9, 0, 64'h4A, 64'h0,                 0, 0, 64'h0,                 8'h00, 64'h0,                 0, 1, 64'h55,                0};
    vecs[10] = '{2'd1, 2'd2, 1, 64'h24,               64'h0,                4'd10,1, 64'h5B, 64'h7FFF_FFFF_0000_0000, 0, 1, 64'h20,              8'h00, 64'h0,                 1, 1, 64'h0000_0000_7FFF_FFFF, 0};

    reset_n = 1'b0; exe_mem = 1'b0; ex_result = '0; ex_rflags = '0; ex_mem_op = '0;
    ex_size = '0; ex_sext = 1'b0; ex_dest = '0; ex_wb_en = 1'b0;
    mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_rdata = '0;
    tick(); tick();
    chk("rst outputs", {58'd0, mem_blocked, mreq_valid, mreq_we, wb_valid, wb_we, wb_err}, 64'd0);
    chk("rst buses", mreq_addr | mreq_wdata | 64'(mreq_be) | 64'(wb_dest) | wb_data | wb_rflags, 64'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Back-to-back non-memory ops retire every cycle.
    drive_op(2'd0, 2'd0, 0, 64'hAAAA, 64'h0, 4'd11, 1, 64'h1);
    tick();
    chk("b2b wb0 valid", 64'(wb_valid), 64'd1);
    chk("b2b wb0 data", wb_data, 64'hAAAA);
    drive_op(2'd0, 2'd0, 0, 64'hBBBB, 64'h0, 4'd12, 1, 64'h2);
    tick();
    exe_mem = 1'b0;
    chk("b2b wb1 valid", 64'(wb_valid), 64'd1);
    chk("b2b wb1 data", wb_data, 64'hBBBB);
    chk("b2b wb1 dest", 64'(wb_dest), 64'd12);
    tick();
    chk("b2b idle", 64'(wb_valid), 64'd0);

    // Stray response in IDLE/REQ is ignored; held execute result consumed once.
    mresp_valid = 1'b1; mresp_rdata = 64'hFF;
    tick();
    mresp_valid = 1'b0;
    chk("stray idle wb", 64'(wb_valid), 64'd0);
    drive_op(2'd1, 2'd3, 0, 64'h500, 64'h0, 4'd2, 1, 64'h3);
    tick();
    drive_op(2'd0, 2'd0, 0, 64'hC0DE, 64'h0, 4'd13, 1, 64'h4);
    mresp_valid = 1'b1;
    tick();
    mresp_valid = 1'b0;
    chk("stray req wb", 64'(wb_valid), 64'd0);
    chk("stray req valid", 64'(mreq_valid), 64'd1);
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    chk("held wait wb", 64'(wb_valid), 64'd0);
    mresp_valid = 1'b1; mresp_rdata = 64'h1111_2222_3333_4444;
    tick();
    mresp_valid = 1'b0;
    chk("held load data", wb_data, 64'h1111_2222_3333_4444);
    chk("held load dest", 64'(wb_dest), 64'd2);
    tick();
    exe_mem = 1'b0;
    chk("held capture valid", 64'(wb_valid), 64'd1);
    chk("held capture data", wb_data, 64'hC0DE);
    chk("held capture dest", 64'(wb_dest), 64'd13);
    tick();
    chk("held once", 64'(wb_valid), 64'd0);

    // Reset while waiting for a response.
    drive_op(2'd1, 2'd3, 0, 64'h600, 64'h0, 4'd3, 1, 64'h5);
    tick();
    exe_mem = 1'b0;
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    chk("rstw in wait", 64'(mem_blocked), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rstw outputs", {58'd0, mem_blocked, mreq_valid, mreq_we, wb_valid, wb_we, wb_err}, 64'd0);
    chk("rstw buses", mreq_addr | mreq_wdata | 64'(mreq_be) | 64'(wb_dest) | wb_data | wb_rflags, 64'd0);
    mresp_valid = 1'b1; mresp_rdata = 64'h99;
    tick();
    mresp_valid = 1'b0;
    chk("rstw late resp", 64'(wb_valid), 64'd0);
    tick();
    chk("rstw late resp2", 64'(wb_valid), 64'd0);

`ifdef MEM_STAGE_TIMEOUT_EN
    drive_op(2'd1, 2'd3, 0, 64'h700, 64'h0, 4'd4, 1, 64'h6);
    tick();
    drive_op(2'd0, 2'd0, 0, 64'h77, 64'h0, 4'd14, 1, 64'h7);
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    for (int k = 0; k < TMO - 1; k++) begin
      tick();
      chk("tmo early", 64'(wb_valid), 64'd0);
    end
    tick();
    chk("tmo valid", 64'(wb_valid), 64'd1);
    chk("tmo err", 64'(wb_err), 64'd1);
    chk("tmo we", 64'(wb_we), 64'd0);
    chk("tmo blocked", 64'(mem_blocked), 64'd0);
    tick();
    exe_mem = 1'b0;
    chk("tmo next valid", 64'(wb_valid), 64'd1);
    chk("tmo next data", wb_data, 64'h77);
    chk("tmo next err", 64'(wb_err), 64'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
